// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter. Round-robin grant, one burst outstanding,
// zero-latency routing of the shared R channel to the granted requester.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a valid source holds its payload stable until that edge.
module axi_rd_arbiter #(
  parameter int         DATA_BYTE_WIDTH = 32,
  parameter logic [7:0] MAX_LEN         = 8'd15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // requester 0
  input  logic [31:0]                    m0_axi_araddr,
  input  logic [7:0]                     m0_axi_arlen,
  input  logic                           m0_axi_arvalid,
  output logic                           m0_axi_arready,
  output logic [DATA_BYTE_WIDTH*8-1:0]   m0_axi_rdata,
  output logic [1:0]                     m0_axi_rresp,
  output logic                           m0_axi_rlast,
  output logic                           m0_axi_rvalid,
  input  logic                           m0_axi_rready,
  // requester 1
  input  logic [31:0]                    m1_axi_araddr,
  input  logic [7:0]                     m1_axi_arlen,
  input  logic                           m1_axi_arvalid,
  output logic                           m1_axi_arready,
  output logic [DATA_BYTE_WIDTH*8-1:0]   m1_axi_rdata,
  output logic [1:0]                     m1_axi_rresp,
  output logic                           m1_axi_rlast,
  output logic                           m1_axi_rvalid,
  input  logic                           m1_axi_rready,
  // shared slave port
  output logic [3:0]                     s_axi_arid,
  output logic [31:0]                    s_axi_araddr,
  output logic [7:0]                     s_axi_arlen,
  output logic [2:0]                     s_axi_arsize,
  output logic [1:0]                     s_axi_arburst,
  output logic                           s_axi_arvalid,
  input  logic                           s_axi_arready,
  input  logic [3:0]                     s_axi_rid,
  input  logic [DATA_BYTE_WIDTH*8-1:0]   s_axi_rdata,
  input  logic [1:0]                     s_axi_rresp,
  input  logic                           s_axi_rlast,
  input  logic                           s_axi_rvalid,
  output logic                           s_axi_rready,
  // status
  output logic                           busy,
  output logic                           grant_idx,
  output logic                           len_err,
  output logic [1:0]                     fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant_q, grant_nxt, do_grant;
  logic [31:0] addr_q, req_addr;
  logic [7:0]  len_q, req_len, sel_len;
  logic [7:0]  beat_cnt;
  logic        cnt_full;
  logic        len_err_q;
  logic        in_addr, in_data, beat, beat_err;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  // A beat moves only while a burst is in its data phase
  assign s_axi_rready = in_data & (grant_q ? m1_axi_rready : m0_axi_rready);
  assign beat         = in_data & s_axi_rvalid & s_axi_rready;

  // Counter stops at MAX_LEN+1 so a runaway slave cannot wrap it
  assign cnt_full = ({1'b0, beat_cnt} >= ({1'b0, MAX_LEN} + 9'd1));

  // Short burst (rlast before the latched length) or a foreign ID
  assign beat_err = (s_axi_rlast && (beat_cnt != len_q)) || (s_axi_rid != s_axi_arid);

  // Request payload of whoever is being granted this cycle, length clamped
  assign req_addr = grant_nxt ? m1_axi_araddr : m0_axi_araddr;
  assign sel_len  = grant_nxt ? m1_axi_arlen  : m0_axi_arlen;
  assign req_len  = (sel_len > MAX_LEN) ? MAX_LEN : sel_len;

  // Next-state logic and round-robin grant decision
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    do_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_axi_arvalid || m1_axi_arvalid) begin
          do_grant  = 1'b1;
          state_nxt = ADDR;
          if (m0_axi_arvalid && m1_axi_arvalid) grant_nxt = ~last_grant;
          else                                  grant_nxt = m1_axi_arvalid;
        end
      end
      ADDR:    if (s_axi_arready)       state_nxt = DATA;
      DATA:    if (beat && s_axi_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Burst context: grant, address, length, beat count and fairness history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
    end else begin
      if (do_grant) begin
        grant_q  <= grant_nxt;
        addr_q   <= req_addr;
        len_q    <= req_len;
        beat_cnt <= '0;
      end else if (beat) begin
        if (!cnt_full) beat_cnt <= beat_cnt + 8'd1;
        if (s_axi_rlast) last_grant <= grant_q;
      end
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                len_err_q <= 1'b0;
    else if (beat && beat_err) len_err_q <= 1'b1;
  end

  // Shared address channel
  assign s_axi_arvalid = in_addr;
  assign s_axi_arid    = {3'b000, grant_q};
  assign s_axi_araddr  = addr_q;
  assign s_axi_arlen   = len_q;
  assign s_axi_arsize  = 3'b101;
  assign s_axi_arburst = 2'b01;

  assign m0_axi_arready = in_addr & ~grant_q & s_axi_arready;
  assign m1_axi_arready = in_addr &  grant_q & s_axi_arready;

  // Read data is broadcast; qualifiers go only to the granted requester
  assign m0_axi_rdata  = s_axi_rdata;
  assign m1_axi_rdata  = s_axi_rdata;
  assign m0_axi_rvalid = in_data & ~grant_q & s_axi_rvalid;
  assign m1_axi_rvalid = in_data &  grant_q & s_axi_rvalid;
  assign m0_axi_rlast  = in_data & ~grant_q & s_axi_rlast;
  assign m1_axi_rlast  = in_data &  grant_q & s_axi_rlast;
  assign m0_axi_rresp  = (in_data & ~grant_q) ? s_axi_rresp : 2'b00;
  assign m1_axi_rresp  = (in_data &  grant_q) ? s_axi_rresp : 2'b00;

  // Status
  assign busy      = (state != IDLE);
  assign grant_idx = grant_q;
  assign len_err   = len_err_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: requester drivers, a slave model and a
// scoreboard whose expected AR order comes from a round-robin reference model.
module tb_axi_rd_arbiter;
  localparam int         DW      = 256;
  localparam logic [7:0] MAX_LEN = 8'd15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] m_araddr [2];
  logic [7:0]  m_arlen  [2];
  logic [1:0]  m_arvalid, m_rready;
  logic        m0_axi_arready, m1_axi_arready;
  logic [DW-1:0] m0_axi_rdata, m1_axi_rdata;
  logic [1:0]  m0_axi_rresp, m1_axi_rresp;
  logic        m0_axi_rlast, m1_axi_rlast, m0_axi_rvalid, m1_axi_rvalid;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid, s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic        busy, grant_idx, len_err;
  logic [1:0]  fsm_state;

  axi_rd_arbiter #(.DATA_BYTE_WIDTH(32), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_axi_araddr(m_araddr[0]), .m0_axi_arlen(m_arlen[0]), .m0_axi_arvalid(m_arvalid[0]),
    .m0_axi_arready(m0_axi_arready), .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp),
    .m0_axi_rlast(m0_axi_rlast), .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m_rready[0]),
    .m1_axi_araddr(m_araddr[1]), .m1_axi_arlen(m_arlen[1]), .m1_axi_arvalid(m_arvalid[1]),
    .m1_axi_arready(m1_axi_arready), .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp),
    .m1_axi_rlast(m1_axi_rlast), .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m_rready[1]),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .busy(busy), .grant_idx(grant_idx), .len_err(len_err),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [43:0]   exp_ar_q[$];              // {arid, araddr, arlen}
  logic [DW+2:0] exp_r_q0[$], exp_r_q1[$]; // {rdata, rresp, rlast}
  logic [39:0]   req_q0[$], req_q1[$];     // pending requester commands {addr, len}
  logic [39:0]   stage0[$], stage1[$];     // requests staged for the next launch

  logic model_last;   // reference round-robin history
  logic exp_len_err;
  logic mon_en;
  int   ar_pulses, beats_rx0;

  // sampled handshakes (taken at negedge, consumed after the next posedge)
  logic [1:0] ar_hs;
  logic       s_ar_hs, r_hs;
  logic [3:0] hs_id;
  logic [7:0] hs_len;
  logic       prev_pend;
  logic [43:0] prev_ar;

  // driver / slave model state
  int   hold_low [2];
  logic rr_random;
  int   sl_state, sl_delay, delay_once, early_at;
  logic early_pending, bad_rid_pending;
  logic [3:0] sl_id;
  logic [7:0] sl_len, sl_beat;

  task automatic chk(input string name, input logic [DW+2:0] act, input logic [DW+2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] clamp_len(input logic [7:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

  task automatic add_req(input int n, input logic [31:0] addr, input logic [7:0] len);
    if (n == 0) stage0.push_back({addr, len});
    else        stage1.push_back({addr, len});
  endtask

  // Both requesters always have their next command waiting when the arbiter
  // is free, so the grant order is pure alternation until one list runs dry.
  task automatic launch();
    logic        pick;
    logic [39:0] e;
    while (stage0.size() > 0 || stage1.size() > 0) begin
      if (stage0.size() > 0 && stage1.size() > 0) pick = ~model_last;
      else                                        pick = (stage1.size() > 0);
      if (pick) begin e = stage1.pop_front(); req_q1.push_back(e); end
      else      begin e = stage0.pop_front(); req_q0.push_back(e); end
      exp_ar_q.push_back({3'b000, pick, e[39:8], clamp_len(e[7:0])});
      model_last = pick;
    end
  endtask

  // ---------------- drivers (run just after each posedge) ----------------
  task automatic step_masters();
    for (int n = 0; n < 2; n++) begin
      if (ar_hs[n]) m_arvalid[n] = 1'b0;
      if (!m_arvalid[n]) begin
        if (n == 0 && req_q0.size() > 0) begin
          {m_araddr[0], m_arlen[0]} = req_q0.pop_front(); m_arvalid[0] = 1'b1;
        end else if (n == 1 && req_q1.size() > 0) begin
          {m_araddr[1], m_arlen[1]} = req_q1.pop_front(); m_arvalid[1] = 1'b1;
        end
      end
      if (hold_low[n] > 0) begin
        m_rready[n] = 1'b0;
        hold_low[n]--;
      end else begin
        m_rready[n] = rr_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  endtask

  task automatic step_slave();
    logic [DW+2:0] ent;
    case (sl_state)
      0: begin
        s_axi_arready = 1'b0;
        if (s_axi_arvalid) begin
          if (delay_once >= 0) begin sl_delay = delay_once; delay_once = -1; end
          else sl_delay = int'($urandom_range(0, 3));
          sl_state = 1;
        end
      end
      1: begin
        if (s_ar_hs) begin
          s_axi_arready = 1'b0;
          sl_id = hs_id; sl_len = hs_len; sl_beat = 8'd0;
          sl_state = 2;
        end else if (sl_delay == 0) s_axi_arready = 1'b1;
        else sl_delay--;
      end
      default: begin
        if (r_hs) begin
          if (s_axi_rlast) sl_state = 0;
          else             sl_beat = sl_beat + 8'd1;
          s_axi_rvalid = 1'b0;
        end
        if (sl_state == 2 && !s_axi_rvalid && $urandom_range(0, 3) != 0) begin
          s_axi_rvalid = 1'b1;
          for (int i = 0; i < DW / 32; i++) s_axi_rdata[i*32 +: 32] = $urandom();
          s_axi_rresp = 2'($urandom_range(0, 3));
          s_axi_rlast = (sl_beat == sl_len);
          if (early_pending && int'(sl_beat) == early_at && sl_len > sl_beat) begin
            s_axi_rlast = 1'b1; early_pending = 1'b0; exp_len_err = 1'b1;
          end
          s_axi_rid = sl_id;
          if (bad_rid_pending) begin
            s_axi_rid = sl_id ^ 4'h2; bad_rid_pending = 1'b0; exp_len_err = 1'b1;
          end
          ent = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
          if (sl_id[0]) exp_r_q1.push_back(ent);
          else          exp_r_q0.push_back(ent);
        end
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      step_masters();
      step_slave();
    end
  end

  // ---------------- monitor / checker (negedge) ----------------
  always @(negedge clk) begin
    logic [DW+2:0] e;
    logic          g;
    if (!rst_n) begin
      ar_hs = 2'b00; s_ar_hs = 1'b0; r_hs = 1'b0; prev_pend = 1'b0;
    end else begin
      ar_hs   = {m_arvalid[1] & m1_axi_arready, m_arvalid[0] & m0_axi_arready};
      s_ar_hs = s_axi_arvalid & s_axi_arready;
      hs_id   = s_axi_arid;
      hs_len  = s_axi_arlen;
      r_hs    = s_axi_rvalid & s_axi_rready;
      if (mon_en) begin
        // address channel
        if (prev_pend)
          chk("ar_stable", {s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen}, {1'b1, prev_ar});
        if (s_ar_hs) begin
          ar_pulses++;
          if (exp_ar_q.size() == 0) chk("ar_unexpected", {s_axi_arid, s_axi_araddr, s_axi_arlen}, '0);
          else chk("ar_payload", {s_axi_arid, s_axi_araddr, s_axi_arlen}, exp_ar_q.pop_front());
          chk("ar_const", {s_axi_arsize, s_axi_arburst}, {3'b101, 2'b01});
          chk("m_arready", {m1_axi_arready, m0_axi_arready}, s_axi_arid[0] ? 2'b10 : 2'b01);
          chk("grant_idx", grant_idx, s_axi_arid[0]);
        end else begin
          chk("m_arready_idle", {m1_axi_arready, m0_axi_arready}, 2'b00);
        end
        prev_pend = s_axi_arvalid & ~s_axi_arready;
        prev_ar   = {s_axi_arid, s_axi_araddr, s_axi_arlen};
        // data routing
        if (sl_state == 2) begin
          g = sl_id[0];
          chk("busy_data", busy, 1'b1);
          chk("s_rready", s_axi_rready, m_rready[g]);
          chk("m_rvalid", {m1_axi_rvalid, m0_axi_rvalid}, g ? {s_axi_rvalid, 1'b0} : {1'b0, s_axi_rvalid});
        end else begin
          chk("r_quiet", {s_axi_rready, m1_axi_rvalid, m0_axi_rvalid}, 3'b000);
        end
        if (m0_axi_rvalid && m_rready[0]) begin
          beats_rx0++;
          e = (exp_r_q0.size() > 0) ? exp_r_q0.pop_front() : '0;
          chk("r0_beat", {m0_axi_rdata, m0_axi_rresp, m0_axi_rlast}, e);
        end
        if (m1_axi_rvalid && m_rready[1]) begin
          e = (exp_r_q1.size() > 0) ? exp_r_q1.pop_front() : '0;
          chk("r1_beat", {m1_axi_rdata, m1_axi_rresp, m1_axi_rlast}, e);
        end
      end
    end
  end

  // ---------------- phase helpers ----------------
  task automatic drain(input string name);
    int cyc = 0;
    while (!(exp_ar_q.size() == 0 && req_q0.size() == 0 && req_q1.size() == 0 &&
             m_arvalid == 2'b00 && sl_state == 0 &&
             exp_r_q0.size() == 0 && exp_r_q1.size() == 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: still pending after %0d cycles, required drained", name, cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic flush_tb();
    exp_ar_q.delete(); exp_r_q0.delete(); exp_r_q1.delete();
    req_q0.delete(); req_q1.delete(); stage0.delete(); stage1.delete();
    m_arvalid = 2'b00; hold_low[0] = 0; hold_low[1] = 0;
    sl_state = 0; s_axi_arready = 1'b0; s_axi_rvalid = 1'b0; s_axi_rlast = 1'b0;
    early_pending = 1'b0; bad_rid_pending = 1'b0;
    model_last = 1'b1; exp_len_err = 1'b0; prev_pend = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int pulses_before;
    rst_n = 1'b0; mon_en = 1'b0;
    m_araddr[0] = '0; m_araddr[1] = '0; m_arlen[0] = '0; m_arlen[1] = '0;
    m_rready = 2'b00; rr_random = 1'b0;
    s_axi_rid = '0; s_axi_rdata = '0; s_axi_rresp = '0;
    flush_tb();
    delay_once = -1; early_at = 7;
    ar_pulses = 0; beats_rx0 = 0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ar", {s_axi_arvalid, s_axi_araddr, s_axi_arlen}, '0);
    chk("rst_s_rready", s_axi_rready, 1'b0);
    chk("rst_m_out", {m0_axi_arready, m1_axi_arready, m0_axi_rvalid, m1_axi_rvalid}, 4'b0000);
    chk("rst_status", {grant_idx, len_err}, 2'b00);
    rst_n = 1'b1; mon_en = 1'b1;

    // tie after reset goes to m0; slow arready; m0 stalls 3 cycles mid-burst
    @(negedge clk);
    delay_once = 5;
    add_req(0, 32'h0000_1000, 8'd15);
    add_req(1, 32'h0000_2000, 8'd15);
    launch();
    cyc = 0;
    while (beats_rx0 < 5 && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("wait_m0_beats", beats_rx0 >= 5, 1'b1);
    hold_low[0] = 3;
    drain("tie");
    chk("tie_pulses", ar_pulses, 2);
    chk("tie_len_err", len_err, 1'b0);

    // random traffic with clamping and random ready on both sides
    rr_random = 1'b1;
    pulses_before = ar_pulses;
    for (int i = 0; i < 6; i++) begin
      add_req(0, $urandom() & 32'hFFFF_FFE0, 8'($urandom_range(0, 20)));
      add_req(1, $urandom() & 32'hFFFF_FFE0, 8'($urandom_range(0, 20)));
    end
    add_req(1, 32'h0000_8000, 8'd200);
    launch();
    drain("random");
    chk("random_pulses", ar_pulses - pulses_before, 13);
    chk("random_len_err", len_err, exp_len_err);

    // short burst: rlast on the 8th beat of a 16-beat read
    early_pending = 1'b1; early_at = 7;
    add_req(1, 32'h0000_6000, 8'd15);
    add_req(0, 32'h0000_7000, 8'd2);
    add_req(1, 32'h0000_6100, 8'd4);
    launch();
    drain("early");
    chk("early_len_err", len_err, 1'b1);

    // asynchronous reset while beat 5 of a burst is on the bus
    rr_random = 1'b0;
    add_req(0, 32'h0000_3000, 8'd15);
    launch();
    cyc = 0;
    while (!(sl_state == 2 && sl_beat == 8'd5 && s_axi_rvalid) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    chk("wait_beat5", s_axi_rvalid, 1'b1);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_rready", s_axi_rready, 1'b0);
    chk("arst_rvalid", {m1_axi_rvalid, m0_axi_rvalid}, 2'b00);
    chk("arst_len_err", len_err, 1'b0);
    flush_tb();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1;

    // post-reset tie again goes to m0; a foreign rid flags len_err
    @(negedge clk);
    bad_rid_pending = 1'b1;
    add_req(0, 32'h0000_4000, 8'd3);
    add_req(1, 32'h0000_5000, 8'd3);
    launch();
    drain("post_reset");
    chk("rid_len_err", len_err, 1'b1);
    chk("final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter DATA_BYTE_WIDTH, default 32; R-data width = DATA_BYTE_WIDTH*8 bits (256).
REQ-002 Parameter MAX_LEN, default 8'd15; arlen values above this are clamped to it.
REQ-003 clk  input  1  single clock; all logic rises on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 m0_axi_araddr, m1_axi_araddr  input  32  requester read start address.
REQ-006 m0_axi_arlen, m1_axi_arlen  input  8  requester burst length minus one.
REQ-007 m0_axi_arvalid, m1_axi_arvalid  input  1  requester address valid; held until arready.
REQ-008 m0_axi_arready, m1_axi_arready  output  1  address accepted for that requester.
REQ-009 m0_axi_rdata, m1_axi_rdata  output  256  read data, broadcast from s_axi_rdata.
REQ-010 m0_axi_rresp/rlast/rvalid, m1_axi_rresp/rlast/rvalid  output  2/1/1  read response channel.
REQ-011 m0_axi_rready, m1_axi_rready  input  1  requester data ready.
REQ-012 s_axi_arid/araddr/arlen/arsize/arburst/arvalid  output  4/32/8/3/2/1  shared AXI read address channel.
REQ-013 s_axi_arready  input  1  slave address ready.
REQ-014 s_axi_rid/rdata/rresp/rlast/rvalid  input  4/256/2/1/1  shared AXI read data channel.
REQ-015 s_axi_rready  output  1  shared data ready.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 grant_idx  output  1  index of the current or most recent grant.
REQ-018 len_err  output  1  sticky burst-length or ID error flag.

Function
REQ-019 FSM states: IDLE, ADDR, DATA. Exactly one burst is outstanding at any time.
REQ-020 IDLE: if any mN_axi_arvalid=1, the grant is chosen round-robin; when both are valid, the requester other than last_grant wins; when one is valid, that one wins.
REQ-021 On grant: grant_idx, araddr, min(arlen,MAX_LEN) and a beat counter of 0 are latched; next state ADDR; s_axi_arvalid=1 in the cycle after the grant.
REQ-022 ADDR: s_axi_arvalid and s_axi_araddr/arlen held stable until s_axi_arready=1. mN_axi_arready = (state==ADDR) & (grant_idx==N) & s_axi_arready, combinational, one cycle. On the handshake, next state is DATA and s_axi_arvalid=0.
REQ-023 Constant fields: s_axi_arid = {3'b000, grant_idx}; s_axi_arsize = 3'b101; s_axi_arburst = 2'b01.
REQ-024 DATA: s_axi_rready = granted mN_axi_rready; granted mN_axi_rvalid = s_axi_rvalid; the non-granted rvalid = 0; rresp and rlast are routed the same way. All routing is combinational, zero latency.
REQ-025 Each beat with rvalid & rready increments the beat counter (8-bit, no wrap beyond MAX_LEN+1).
REQ-026 A beat with s_axi_rlast=1 returns the FSM to IDLE and sets last_grant = grant_idx.
REQ-027 len_err is set when rlast arrives with beat count != latched arlen, or when a beat's s_axi_rid != s_axi_arid. Error beats are still forwarded. len_err clears only on reset.
REQ-028 s_axi_rvalid seen in IDLE or ADDR: s_axi_rready stays 0 and no beat is forwarded.
REQ-029 Outside ADDR, both mN_axi_arready = 0. Outside DATA, both mN_axi_rvalid = 0 and s_axi_rready = 0.
REQ-030 Back-to-back: after the last beat there is exactly one IDLE cycle, then a new grant.

Reset
REQ-031 Asynchronous reset takes effect immediately, including mid-burst. Reset values: state IDLE, last_grant=1 (so m0 wins the first tie), grant_idx=0, beat counter 0, len_err=0, busy=0, s_axi_arvalid=0, s_axi_araddr=0, s_axi_arlen=0, s_axi_rready=0, all mN outputs 0.

Verification
REQ-032 Both arvalid high after reset, m0 addr 0x1000 and m1 addr 0x2000, arlen 15 -> m0 granted first; s_axi_araddr=0x1000 and arid=0; 16 beats go to m0; then m1 is granted at 0x2000 with arid=1.
REQ-033 s_axi_arready held low for 5 cycles -> s_axi_arvalid and address stay stable for those 5 cycles; mN_axi_arready pulses exactly once.
REQ-034 m0 drops rready for 3 cycles mid-burst -> s_axi_rready = 0 for the same 3 cycles; no beat is lost or duplicated; m1_axi_rvalid stays 0.
REQ-035 Slave asserts rlast on beat 8 of an arlen=15 burst -> len_err=1, FSM returns to IDLE, next grant proceeds normally.
REQ-036 rst_n asserted low during beat 5 -> busy, s_axi_rready and mN_axi_rvalid go to 0 without waiting for clk; after release the first tie goes to m0.
